ex_mem_stage: RTL and testbench
===============================

# ex_mem_stage

EX/MEM pipeline stage of the WISC 16-bit core. Captures the execute-stage ALU result, including the saturating nibble-add (PADDSB) lane result, together with destination and write-enable. Owns the architectural flag register (Z, V, N) with per-opcode update rules. Detects HLT retirement through a small state machine. Feeds the memory stage and supplies flags to branch resolution.

## Interface
Parameters:
- none (widths fixed by ISA: 16-bit data, 4-bit opcode, 4-bit register index)

Ports (name, direction, width, meaning):
- clk, input, 1: single clock; all state updates on rising edge
- rst, input, 1: synchronous, active-high reset
- stall, input, 1: hold the current register contents and flags
- flush, input, 1: replace the incoming instruction with a bubble
- in_valid, input, 1: execute stage presents a real instruction
- in_opcode, input, 4: opcode of the incoming instruction
- in_result, input, 16: ALU result (ADD/SUB/XOR/shift/PADDSB/RED/LLB/LHB/PCS/address)
- in_ovfl, input, 1: signed overflow from the ALU adder (ADD/SUB only meaningful)
- in_dst, input, 4: destination register index
- in_wen, input, 1: instruction writes the register file
- out_valid, output, 1: registered valid
- out_opcode, output, 4: registered opcode
- out_result, output, 16: registered result
- out_dst, output, 4: registered destination
- out_wen, output, 1: registered write enable, forced 0 when out_valid=0
- flag_z, output, 1: zero flag
- flag_v, output, 1: overflow flag
- flag_n, output, 1: negative flag
- halted, output, 1: HLT has retired; core is frozen

## Operation
- Accept condition: accept = in_valid & ~stall & ~flush & (state==RUN).
- Pipeline register update, by priority:
  - rst: all outputs 0.
  - halted state: hold unchanged.
  - flush: bubble (valid=0, wen=0, opcode=0, result=0, dst=0).
  - stall: hold.
  - else: capture inputs. out_wen = in_wen & in_valid.
- Flag update occurs only on accept:
  - ADD (0000), SUB (0001): Z = (in_result==0); V = in_ovfl; N = in_result[15].
  - XOR (0010), SLL (0100), SRA (0101), ROR (0110): Z only; V and N hold.
  - PADDSB (0111), RED (0011), and all others: no flag change.
  - PADDSB saturation is never reported through V.
- State machine:
  - RUN → HALT_PEND on accept of HLT (1111).
  - HALT_PEND → HALTED on the next cycle, unconditionally.
  - HALTED is held until rst.
- halted = (state==HALTED).
- In HALT_PEND and HALTED, new inputs are ignored regardless of stall/flush.
- HLT itself has out_wen=0.

## Timing
- Latency: one cycle. Values captured at edge k appear on outputs after edge k.
- Flags updated at the same edge as the register capture. A branch in the following cycle sees the new flags; there is no bypass of same-cycle flags.
- Reset values: every output is 0, including all three flags; state = RUN.
- rst asserted mid-operation (including HALT_PEND/HALTED): returns to RUN with outputs 0 at the next edge.
- stall and flush together: flush wins. A bubble is inserted and flags are not updated.
- stall while in_valid: the instruction stays pending upstream; the pipeline register and flags both hold.
- in_valid=0 with no stall/flush: a bubble is captured and flags hold.
- HLT accepted while a flush arrives in the same cycle: flush wins and HLT is discarded.

## Structure
- Shared package wisc_pkg:
  - opcode constants (OP_ADD..OP_HLT)
  - flag index constants (FLAG_Z, FLAG_V, FLAG_N)
  - halt state encoding (RUN, HALT_PEND, HALTED)
- Sub-module flag_reg:
  - 3-bit register with per-bit enable, next-value inputs, and sync reset.
  - Instantiated once. Enables are decoded here from opcode and accept.

## Test plan
- Reset then idle: all outputs 0, halted=0, for 3 cycles with in_valid=0.
- ADD with result 0x8000, in_ovfl=1, dst=3, wen=1: next cycle out_result=0x8000, out_dst=3, out_wen=1, Z=0, V=1, N=1.
- PADDSB with result 0xF0F0 after flags Z=0/V=1/N=1: out_result=0xF0F0; flags unchanged. Then XOR with result 0: Z=1, V=1, N=1.
- stall=1 for 2 cycles during SUB (result 0x0000): outputs and flags hold the prior values. On release, Z=1, V=in_ovfl, N=0.
- stall=1 and flush=1 with ADD in_valid=1: out_valid=0, out_wen=0, flags unchanged.
- HLT accepted: halted=1 exactly two edges later. Subsequent ADD inputs are ignored. rst clears halted and all outputs at the next edge.

Source files
------------

// File: rtl/wisc_pkg.sv
// Shared WISC ISA constants: opcodes, flag bit positions and the halt-detect state encoding.
package wisc_pkg;

  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_SUB    = 4'h1;
  localparam logic [3:0] OP_XOR    = 4'h2;
  localparam logic [3:0] OP_RED    = 4'h3;
  localparam logic [3:0] OP_SLL    = 4'h4;
  localparam logic [3:0] OP_SRA    = 4'h5;
  localparam logic [3:0] OP_ROR    = 4'h6;
  localparam logic [3:0] OP_PADDSB = 4'h7;
  localparam logic [3:0] OP_LW     = 4'h8;
  localparam logic [3:0] OP_SW     = 4'h9;
  localparam logic [3:0] OP_LLB    = 4'hA;
  localparam logic [3:0] OP_LHB    = 4'hB;
  localparam logic [3:0] OP_B      = 4'hC;
  localparam logic [3:0] OP_BR     = 4'hD;
  localparam logic [3:0] OP_PCS    = 4'hE;
  localparam logic [3:0] OP_HLT    = 4'hF;

  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_N = 2;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    HALT_PEND = 2'd1,
    HALTED    = 2'd2
  } halt_state_e;

endpackage

// File: rtl/ex_mem_stage_flag_reg.sv
// Architectural Z/V/N flag register: each bit loads its next value only when its enable is set.
module flag_reg (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] en_i,
  input  logic [2:0] d_i,
  output logic [2:0] q_o
);

  logic [2:0] flags_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= '0;
    end else begin
      for (int unsigned i = 0; i < 3; i++) begin
        if (en_i[i]) flags_q[i] <= d_i[i];
      end
    end
  end

  assign q_o = flags_q;

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register for the WISC core: result capture, Z/V/N flag ownership and HLT retirement.
module ex_mem_stage
  import wisc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        in_valid,
  input  logic [3:0]  in_opcode,
  input  logic [15:0] in_result,
  input  logic        in_ovfl,
  input  logic [3:0]  in_dst,
  input  logic        in_wen,
  output logic        out_valid,
  output logic [3:0]  out_opcode,
  output logic [15:0] out_result,
  output logic [3:0]  out_dst,
  output logic        out_wen,
  output logic        flag_z,
  output logic        flag_v,
  output logic        flag_n,
  output logic        halted
);

  halt_state_e state_q, state_d;
  logic        accept;
  logic        valid_q, valid_d;
  logic [3:0]  opcode_q, opcode_d;
  logic [15:0] result_q, result_d;
  logic [3:0]  dst_q, dst_d;
  logic        wen_q, wen_d;
  logic [2:0]  flag_en, flag_nxt, flags;

  assign accept = in_valid & ~stall & ~flush & (state_q == RUN);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:       if (accept && in_opcode == OP_HLT) state_d = HALT_PEND;
      HALT_PEND: state_d = HALTED;
      HALTED:    state_d = HALTED;
      default:   state_d = RUN;
    endcase
  end

  // Once HLT is accepted the register freezes, so flush/stall no longer matter.
  always_comb begin
    valid_d  = valid_q;
    opcode_d = opcode_q;
    result_d = result_q;
    dst_d    = dst_q;
    wen_d    = wen_q;
    if (state_q != RUN) begin
      valid_d = valid_q;
    end else if (flush || (!stall && !in_valid)) begin
      valid_d  = 1'b0;
      opcode_d = '0;
      result_d = '0;
      dst_d    = '0;
      wen_d    = 1'b0;
    end else if (!stall) begin
      valid_d  = 1'b1;
      opcode_d = in_opcode;
      result_d = in_result;
      dst_d    = in_dst;
      wen_d    = in_wen & (in_opcode != OP_HLT);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      valid_q  <= 1'b0;
      opcode_q <= '0;
      result_q <= '0;
      dst_q    <= '0;
      wen_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      opcode_q <= opcode_d;
      result_q <= result_d;
      dst_q    <= dst_d;
      wen_q    <= wen_d;
    end
  end

  // PADDSB saturation deliberately never reaches V; only the adder ops touch V/N.
  always_comb begin
    flag_en          = '0;
    flag_nxt         = '0;
    flag_nxt[FLAG_Z] = (in_result == 16'h0000);
    flag_nxt[FLAG_V] = in_ovfl;
    flag_nxt[FLAG_N] = in_result[15];
    if (accept) begin
      unique case (in_opcode)
        OP_ADD, OP_SUB:                 flag_en = '1;
        OP_XOR, OP_SLL, OP_SRA, OP_ROR: flag_en[FLAG_Z] = 1'b1;
        default:                        flag_en = '0;
      endcase
    end
  end

  flag_reg u_flag_reg (
    .clk  (clk),
    .rst  (rst),
    .en_i (flag_en),
    .d_i  (flag_nxt),
    .q_o  (flags)
  );

  assign out_valid  = valid_q;
  assign out_opcode = opcode_q;
  assign out_result = result_q;
  assign out_dst    = dst_q;
  assign out_wen    = wen_q & valid_q;
  assign flag_z     = flags[FLAG_Z];
  assign flag_v     = flags[FLAG_V];
  assign flag_n     = flags[FLAG_N];
  assign halted     = (state_q == HALTED);

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: each scenario queues hand-derived expectations and compares one per edge.
module tb_ex_mem_stage;
  import wisc_pkg::*;

  typedef struct packed {
    logic        rst;
    logic        v;
    logic [3:0]  op;
    logic [15:0] res;
    logic        ovfl;
    logic [3:0]  dst;
    logic        wen;
    logic        stall;
    logic        flush;
  } stim_t;

  typedef struct packed {
    logic        valid;
    logic [3:0]  op;
    logic [15:0] res;
    logic [3:0]  dst;
    logic        wen;
    logic        z;
    logic        v;
    logic        n;
    logic        h;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, stall, flush, in_valid, in_ovfl, in_wen;
  logic [3:0]  in_opcode, in_dst;
  logic [15:0] in_result;
  logic        out_valid, out_wen, flag_z, flag_v, flag_n, halted;
  logic [3:0]  out_opcode, out_dst;
  logic [15:0] out_result;

  exp_t obs;
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  assign obs = {out_valid, out_opcode, out_result, out_dst, out_wen, flag_z, flag_v, flag_n, halted};

  always #5 clk = ~clk;

  ex_mem_stage dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_opcode  (in_opcode),
    .in_result  (in_result),
    .in_ovfl    (in_ovfl),
    .in_dst     (in_dst),
    .in_wen     (in_wen),
    .out_valid  (out_valid),
    .out_opcode (out_opcode),
    .out_result (out_result),
    .out_dst    (out_dst),
    .out_wen    (out_wen),
    .flag_z     (flag_z),
    .flag_v     (flag_v),
    .flag_n     (flag_n),
    .halted     (halted)
  );

  task automatic apply(input stim_t s);
    rst       = s.rst;
    in_valid  = s.v;
    in_opcode = s.op;
    in_result = s.res;
    in_ovfl   = s.ovfl;
    in_dst    = s.dst;
    in_wen    = s.wen;
    stall     = s.stall;
    flush     = s.flush;
  endtask

  task automatic test_reset();
    stim_t st[5];
    exp_t  ex[5];
    exp_t  e;
    st[0] = '{1'b1, 1'b0, 4'h0, 16'h0000, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0};
    st[1] = st[0];
    st[2] = '{1'b0, 1'b0, 4'h0, 16'h0000, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0};
    st[3] = st[2];
    st[4] = st[2];
    for (int i = 0; i < 5; i++) ex[i] = '0;
    for (int i = 0; i < 5; i++) begin
      apply(st[i]);
      sb.push_back(ex[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL reset step %0d: got %h expected %h", i, obs, e);
      end
    end
  endtask

  task automatic test_add();
    stim_t st;
    exp_t  e;
    st = '{1'b0, 1'b1, OP_ADD, 16'h8000, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0};
    apply(st);
    sb.push_back('{1'b1, OP_ADD, 16'h8000, 4'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0});
    @(posedge clk); #1;
    e = sb.pop_front();
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL add_flags: got %h expected %h", obs, e);
    end
  endtask

  task automatic test_paddsb_xor();
    stim_t st[4];
    exp_t  ex[4];
    exp_t  e;
    st[0] = '{1'b0, 1'b1, OP_PADDSB, 16'hF0F0, 1'b1, 4'd4, 1'b1, 1'b0, 1'b0};
    ex[0] = '{1'b1, OP_PADDSB, 16'hF0F0, 4'd4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    st[1] = '{1'b0, 1'b1, OP_XOR, 16'h0000, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0};
    ex[1] = '{1'b1, OP_XOR, 16'h0000, 4'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    st[2] = '{1'b0, 1'b1, OP_SLL, 16'h0002, 1'b0, 4'd5, 1'b1, 1'b0, 1'b0};
    ex[2] = '{1'b1, OP_SLL, 16'h0002, 4'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    st[3] = '{1'b0, 1'b1, OP_RED, 16'h0000, 1'b0, 4'd6, 1'b1, 1'b0, 1'b0};
    ex[3] = '{1'b1, OP_RED, 16'h0000, 4'd6, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      apply(st[i]);
      sb.push_back(ex[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL paddsb_xor step %0d: got %h expected %h", i, obs, e);
      end
    end
  endtask

  task automatic test_stall();
    stim_t st[4];
    exp_t  ex[4];
    exp_t  e;
    st[0] = '{1'b0, 1'b1, OP_ADD, 16'h1234, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0};
    ex[0] = '{1'b1, OP_ADD, 16'h1234, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    st[1] = '{1'b0, 1'b1, OP_SUB, 16'h0000, 1'b0, 4'd6, 1'b1, 1'b1, 1'b0};
    ex[1] = ex[0];
    st[2] = st[1];
    ex[2] = ex[0];
    st[3] = '{1'b0, 1'b1, OP_SUB, 16'h0000, 1'b0, 4'd6, 1'b1, 1'b0, 1'b0};
    ex[3] = '{1'b1, OP_SUB, 16'h0000, 4'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      apply(st[i]);
      sb.push_back(ex[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL stall step %0d: got %h expected %h", i, obs, e);
      end
    end
  endtask

  task automatic test_flush();
    stim_t st[5];
    exp_t  ex[5];
    exp_t  e;
    exp_t  bubble;
    bubble = '{1'b0, 4'h0, 16'h0000, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    st[0] = '{1'b0, 1'b1, OP_ADD, 16'h8000, 1'b1, 4'd2, 1'b1, 1'b1, 1'b1};
    st[1] = '{1'b0, 1'b1, OP_ADD, 16'h8000, 1'b1, 4'd2, 1'b1, 1'b0, 1'b1};
    st[2] = '{1'b0, 1'b0, OP_ADD, 16'h0000, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0};
    st[3] = '{1'b0, 1'b1, OP_HLT, 16'h0000, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1};
    st[4] = '{1'b0, 1'b0, OP_ADD, 16'h0000, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) ex[i] = bubble;
    for (int i = 0; i < 5; i++) begin
      apply(st[i]);
      sb.push_back(ex[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL flush step %0d: got %h expected %h", i, obs, e);
      end
    end
  endtask

  task automatic test_hlt();
    stim_t st[5];
    exp_t  ex[5];
    exp_t  e;
    st[0] = '{1'b0, 1'b1, OP_HLT, 16'h0000, 1'b0, 4'd7, 1'b1, 1'b0, 1'b0};
    ex[0] = '{1'b1, OP_HLT, 16'h0000, 4'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    st[1] = '{1'b0, 1'b1, OP_ADD, 16'h8000, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0};
    ex[1] = '{1'b1, OP_HLT, 16'h0000, 4'd7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    st[2] = '{1'b0, 1'b1, OP_ADD, 16'h8000, 1'b1, 4'd2, 1'b1, 1'b0, 1'b1};
    ex[2] = ex[1];
    st[3] = '{1'b1, 1'b1, OP_ADD, 16'h8000, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0};
    ex[3] = '0;
    st[4] = '{1'b0, 1'b1, OP_ADD, 16'h0000, 1'b0, 4'd9, 1'b1, 1'b0, 1'b0};
    ex[4] = '{1'b1, OP_ADD, 16'h0000, 4'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      apply(st[i]);
      sb.push_back(ex[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL hlt step %0d: got %h expected %h", i, obs, e);
      end
    end
  endtask

  initial begin
    apply('{1'b1, 1'b0, 4'h0, 16'h0000, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0});
    test_reset();
    test_add();
    test_paddsb_xor();
    test_stall();
    test_flush();
    test_hlt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
